hamming_scrub_ctrl: RTL and testbench
=====================================

// Module: hamming_scrub_ctrl
// PURPOSE
// Background scrubber for a Hamming-SECDED protected memory. Walks addresses START..END, reads each
// codeword, drives it into a hamming_decode instance, and writes back the corrected codeword on a
// single-bit error. Counts corrected and uncorrectable words and logs the first uncorrectable address.
// Sits between the memory arbiter port and the decoder; it owns the sequencing of both.
// PARAMETERS
// DATA_WIDTH   25   payload bits per word; must match the attached hamming_decode
// CODED_WIDTH  DATA_WIDTH+hamming_address_width(DATA_WIDTH)+1   codeword bits (derived, gray_area_package)
// LOC_WIDTH    hamming_address_width(DATA_WIDTH)   width of decoder fault location (derived)
// MEM_AW       8    memory address width
// CNT_W        16   width of the error counters
// PORTS
// clk            in   1            clock
// rst            in   1            synchronous reset, active-high
// start_i        in   1            one-cycle pulse: begin a pass (ignored while busy_o=1)
// stop_i         in   1            level: abort pass at next safe point
// start_addr_i   in   MEM_AW       first address, sampled on accepted start_i
// end_addr_i     in   MEM_AW       last address inclusive, sampled on accepted start_i
// busy_o         out  1            pass in progress
// done_o         out  1            one-cycle pulse at pass end (normal or aborted)
// mem_req_o      out  1            memory request valid
// mem_we_o       out  1            1=write, 0=read; stable while mem_req_o=1
// mem_addr_o     out  MEM_AW       request address; stable while mem_req_o=1
// mem_wdata_o    out  CODED_WIDTH  write codeword; stable while mem_req_o=1
// mem_gnt_i      in   1            request accepted when mem_req_o&mem_gnt_i
// mem_rvalid_i   in   1            read data valid (>=1 cycle after read grant)
// mem_rdata_i    in   CODED_WIDTH  read codeword
// dec_data_o     out  CODED_WIDTH  codeword to decoder (registered read data)
// dec_loc_i      in   LOC_WIDTH    decoder fault location
// dec_nerr_i     in   2            decoder error count (0,1,2)
// corr_cnt_o     out  CNT_W        words corrected this pass
// uncorr_cnt_o   out  CNT_W        uncorrectable words this pass
// first_bad_o    out  MEM_AW       address of first uncorrectable word
// first_bad_vld_o out 1            first_bad_o valid
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; counters and first_bad cleared. Reset mid-pass drops any
//   outstanding request with no write-back; a late mem_rvalid_i after reset is ignored.
// - FSM: IDLE -> RD_REQ on start_i. RD_REQ: mem_req_o=1, we=0 until gnt -> RD_WAIT.
//   RD_WAIT: on mem_rvalid_i capture mem_rdata_i into dec_data_o -> CHECK.
//   CHECK (1 cycle, decoder combinational): nerr=0 -> NEXT; nerr=1 and dec_loc_i<CODED_WIDTH ->
//   WR_REQ with wdata = dec_data_o with bit dec_loc_i inverted, corr_cnt++; nerr=1 with
//   loc>=CODED_WIDTH, nerr=2 or nerr=3 -> uncorr_cnt++, log address if first_bad_vld_o=0, -> NEXT.
//   WR_REQ: mem_req_o=1, we=1 until gnt -> NEXT. NEXT: addr==end -> DONE else addr+1 -> RD_REQ.
//   DONE: done_o=1 one cycle, busy_o=0 from next cycle -> IDLE.
// - busy_o=1 in every state except IDLE. Counters/first_bad cleared on accepted start_i, held after DONE.
// - Counters saturate at 2^CNT_W-1, no wrap.
// - Address wrap: if end_addr < start_addr the pass wraps through 2^MEM_AW-1 to 0 and ends at end.
//   start==end scrubs exactly one word.
// - stop_i sampled only in NEXT (never abandons a granted read or a pending write-back): -> DONE.
// - start_i while busy_o=1 ignored. stop_i and start_i in IDLE same cycle: start wins, stop acts at NEXT.
// - Minimum per-word latency with gnt and rvalid 1 cycle after: clean 4 cycles, corrected 5 cycles.
// TESTING
// - start 0..3, all clean words -> 4 reads, no writes, corr=0, uncorr=0, done_o one pulse.
// - addr 2 has bit 5 flipped (dec nerr=1, loc=5) -> one write to addr 2 with bit 5 restored, corr=1.
// - addr 1 double error (nerr=2) -> no write, uncorr=1, first_bad=1, vld=1; later bad addr 3 keeps first_bad=1.
// - start=0xFE end=0x01 -> reads 0xFE,0xFF,0x00,0x01 in order then done_o.
// - gnt held low 10 cycles during write-back -> req/we/addr/wdata stable; stop_i asserted then -> write
//   completes, done_o next pass through NEXT, no further reads.
// - rst asserted in RD_WAIT -> all outputs 0 next cycle; later rvalid ignored; counters 0.

Source files
------------

// File: rtl/hamming_scrub_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hamming_scrub_ctrl
// Description : Background SECDED scrubber. Reads START..END (wrapping), writes
//               back single-bit corrections, counts and logs bad words.
// Revision    : 1.0  initial release
// ============================================================================
module hamming_scrub_ctrl #(
    parameter  int DATA_WIDTH  = 25,
    parameter  int MEM_AW      = 8,
    parameter  int CNT_W       = 16,
    localparam int LOC_WIDTH   = $clog2(DATA_WIDTH + 1 + $clog2(DATA_WIDTH + 1)),
    localparam int CODED_WIDTH = DATA_WIDTH + LOC_WIDTH + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic                   stop_i,
    input  logic [MEM_AW-1:0]      start_addr_i,
    input  logic [MEM_AW-1:0]      end_addr_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [MEM_AW-1:0]      mem_addr_o,
    output logic [CODED_WIDTH-1:0] mem_wdata_o,
    input  logic                   mem_gnt_i,
    input  logic                   mem_rvalid_i,
    input  logic [CODED_WIDTH-1:0] mem_rdata_i,
    output logic [CODED_WIDTH-1:0] dec_data_o,
    input  logic [LOC_WIDTH-1:0]   dec_loc_i,
    input  logic [1:0]             dec_nerr_i,
    output logic [CNT_W-1:0]       corr_cnt_o,
    output logic [CNT_W-1:0]       uncorr_cnt_o,
    output logic [MEM_AW-1:0]      first_bad_o,
    output logic                   first_bad_vld_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_CHECK   = 3'd3,
        S_WR_REQ  = 3'd4,
        S_NEXT    = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    // One extra bit so a location equal to or beyond CODED_WIDTH is representable.
    localparam logic [LOC_WIDTH:0] c_coded_width = (LOC_WIDTH + 1)'(CODED_WIDTH);

    state_t                 r_state;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_req;
    logic                   r_we;
    logic [MEM_AW-1:0]      r_addr;
    logic [MEM_AW-1:0]      r_end;
    logic [CODED_WIDTH-1:0] r_wdata;
    logic [CODED_WIDTH-1:0] r_dec_data;
    logic [CNT_W-1:0]       r_corr;
    logic [CNT_W-1:0]       r_uncorr;
    logic [MEM_AW-1:0]      r_first_bad;
    logic                   r_first_vld;

    logic [CODED_WIDTH-1:0] w_flip_mask;
    logic                   w_loc_ok;

    assign w_flip_mask = {{(CODED_WIDTH-1){1'b0}}, 1'b1} << dec_loc_i;
    assign w_loc_ok    = ({1'b0, dec_loc_i} < c_coded_width);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_end       <= '0;
            r_wdata     <= '0;
            r_dec_data  <= '0;
            r_corr      <= '0;
            r_uncorr    <= '0;
            r_first_bad <= '0;
            r_first_vld <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_addr      <= start_addr_i;
                        r_end       <= end_addr_i;
                        r_corr      <= '0;
                        r_uncorr    <= '0;
                        r_first_bad <= '0;
                        r_first_vld <= 1'b0;
                        r_busy      <= 1'b1;
                        r_req       <= 1'b1;
                        r_we        <= 1'b0;
                        r_state     <= S_RD_REQ;
                    end
                end
                S_RD_REQ: begin
                    if (mem_gnt_i) begin
                        r_req   <= 1'b0;
                        r_state <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (mem_rvalid_i) begin
                        r_dec_data <= mem_rdata_i;
                        r_state    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (dec_nerr_i == 2'd0) begin
                        r_state <= S_NEXT;
                    end else if (dec_nerr_i == 2'd1 && w_loc_ok) begin
                        r_wdata <= r_dec_data ^ w_flip_mask;
                        r_req   <= 1'b1;
                        r_we    <= 1'b1;
                        if (r_corr != '1)
                            r_corr <= r_corr + 1'b1;
                        r_state <= S_WR_REQ;
                    end else begin
                        if (r_uncorr != '1)
                            r_uncorr <= r_uncorr + 1'b1;
                        if (!r_first_vld) begin
                            r_first_bad <= r_addr;
                            r_first_vld <= 1'b1;
                        end
                        r_state <= S_NEXT;
                    end
                end
                S_WR_REQ: begin
                    if (mem_gnt_i) begin
                        r_req   <= 1'b0;
                        r_we    <= 1'b0;
                        r_state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    // Only safe point to abort: no read or write-back is outstanding here.
                    if (stop_i || (r_addr == r_end)) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_addr  <= r_addr + 1'b1;
                        r_req   <= 1'b1;
                        r_we    <= 1'b0;
                        r_state <= S_RD_REQ;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_req   <= 1'b0;
                    r_we    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o          = r_busy;
    assign done_o          = r_done;
    assign mem_req_o       = r_req;
    assign mem_we_o        = r_we;
    assign mem_addr_o      = r_addr;
    assign mem_wdata_o     = r_wdata;
    assign dec_data_o      = r_dec_data;
    assign corr_cnt_o      = r_corr;
    assign uncorr_cnt_o    = r_uncorr;
    assign first_bad_o     = r_first_bad;
    assign first_bad_vld_o = r_first_vld;

endmodule
`default_nettype wire

// File: tb/tb_hamming_scrub_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hamming_scrub_ctrl
// Description : Directed bench with memory/decoder responder for the scrubber.
// Revision    : 1.0  initial release
// ============================================================================
module tb_hamming_scrub_ctrl;

    localparam int c_cw = 31;
    localparam int c_aw = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start_i = 1'b0;
    logic              stop_i = 1'b0;
    logic [c_aw-1:0]   start_addr_i = '0;
    logic [c_aw-1:0]   end_addr_i = '0;
    logic              busy_o, done_o, mem_req_o, mem_we_o;
    logic [c_aw-1:0]   mem_addr_o;
    logic [c_cw-1:0]   mem_wdata_o;
    logic              mem_gnt_i = 1'b0;
    logic              mem_rvalid_i = 1'b0;
    logic [c_cw-1:0]   mem_rdata_i = '0;
    logic [c_cw-1:0]   dec_data_o;
    logic [4:0]        dec_loc_i = '0;
    logic [1:0]        dec_nerr_i = '0;
    logic [15:0]       corr_cnt_o, uncorr_cnt_o;
    logic [c_aw-1:0]   first_bad_o;
    logic              first_bad_vld_o;

    hamming_scrub_ctrl dut (
        .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i),
        .start_addr_i(start_addr_i), .end_addr_i(end_addr_i),
        .busy_o(busy_o), .done_o(done_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .dec_data_o(dec_data_o),
        .dec_loc_i(dec_loc_i), .dec_nerr_i(dec_nerr_i), .corr_cnt_o(corr_cnt_o),
        .uncorr_cnt_o(uncorr_cnt_o), .first_bad_o(first_bad_o), .first_bad_vld_o(first_bad_vld_o)
    );

    always #5 clk = ~clk;

    logic [c_cw-1:0] mem [256];
    logic [1:0]      nerr_tab [256];
    logic [4:0]      loc_tab [256];
    logic [c_aw-1:0] rd_q [$];
    logic [c_aw-1:0] wr_q [$];
    int              busy_cyc, done_cnt, wr_stall, stall_cyc, rd_delay, rd_delay_addr;
    logic            stall_seen, stable_ok;
    logic [c_aw-1:0] st_addr;
    logic [c_cw-1:0] st_wdata;
    int              total = 0;
    int              bad = 0;

    function automatic logic [c_cw-1:0] gold(input int a);
        logic [31:0] v;
        v = (a * 32'h9E3779B1) ^ 32'h01234567;
        return v[c_cw-1:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory + decoder responder: grants at the first opportunity unless a write
    // stall is armed, returns read data one cycle after grant (plus optional delay).
    initial begin : responder
        logic            g_acc, g_we, rd_pend;
        logic [c_aw-1:0] g_addr, rd_a;
        logic [c_cw-1:0] g_wdata;
        int              rd_cnt;
        g_acc = 0; g_we = 0; rd_pend = 0; g_addr = '0; rd_a = '0; g_wdata = '0; rd_cnt = 0;
        forever begin
            @(negedge clk);
            if (g_acc) begin
                if (g_we) begin
                    mem[g_addr] = g_wdata;
                    wr_q.push_back(g_addr);
                end else begin
                    rd_q.push_back(g_addr);
                    rd_pend = 1;
                    rd_a    = g_addr;
                    rd_cnt  = (g_addr == rd_delay_addr[c_aw-1:0]) ? rd_delay : 0;
                end
            end
            mem_rvalid_i = 1'b0;
            if (rd_pend) begin
                if (rd_cnt == 0) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = mem[rd_a];
                    dec_nerr_i   = nerr_tab[rd_a];
                    dec_loc_i    = loc_tab[rd_a];
                    rd_pend      = 0;
                end else begin
                    rd_cnt--;
                end
            end
            g_acc = 0;
            mem_gnt_i = 1'b0;
            if (mem_req_o && !rst) begin
                if (mem_we_o && wr_stall > 0) begin
                    if (!stall_seen) begin
                        st_addr  = mem_addr_o;
                        st_wdata = mem_wdata_o;
                    end else if (st_addr !== mem_addr_o || st_wdata !== mem_wdata_o || !mem_we_o) begin
                        stable_ok = 0;
                    end
                    stall_seen = 1;
                    wr_stall--;
                    stall_cyc++;
                end else begin
                    mem_gnt_i = 1'b1;
                    g_acc     = 1;
                    g_we      = mem_we_o;
                    g_addr    = mem_addr_o;
                    g_wdata   = mem_wdata_o;
                end
            end
            if (busy_o) busy_cyc++;
            if (done_o) done_cnt++;
        end
    end

    task automatic start_pass(input logic [c_aw-1:0] sa, input logic [c_aw-1:0] ea);
        rd_q.delete();
        wr_q.delete();
        busy_cyc = 0;
        done_cnt = 0;
        start_addr_i = sa;
        end_addr_i   = ea;
        start_i      = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy_o && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, busy_o, 0);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = gold(i);
            nerr_tab[i] = 2'd0;
            loc_tab[i] = 5'd0;
        end
        wr_stall = 0; stall_cyc = 0; rd_delay = 0; rd_delay_addr = 999;
        stall_seen = 0; stable_ok = 1; busy_cyc = 0; done_cnt = 0;
        st_addr = '0; st_wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_busy", busy_o, 0);
        chk("rst_req", {mem_req_o, mem_we_o, done_o}, 0);
        chk("rst_cnt", {corr_cnt_o, uncorr_cnt_o}, 0);
        chk("rst_bad", {first_bad_vld_o, first_bad_o}, 0);

        // Clean pass 0..3; a second start mid-pass must be ignored.
        start_pass(8'd0, 8'd3);
        repeat (3) @(negedge clk);
        start_addr_i = 8'h80; end_addr_i = 8'h81; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        wait_idle("clean_end");
        chk("clean_reads", {rd_q.size(), rd_q[0], rd_q[1], rd_q[2], rd_q[3]}, {32'd4, 32'h00010203});
        chk("clean_writes", wr_q.size(), 0);
        chk("clean_cnt", {corr_cnt_o, uncorr_cnt_o}, 0);
        chk("clean_done", done_cnt, 1);
        chk("clean_lat", busy_cyc, 17);
        chk("clean_dec", dec_data_o, gold(3));

        // Single-bit error at addr 2, bit 5.
        mem[2] = gold(2) ^ 31'(1 << 5);
        nerr_tab[2] = 2'd1; loc_tab[2] = 5'd5;
        start_pass(8'd0, 8'd3);
        wait_idle("corr_end");
        nerr_tab[2] = 2'd0;
        chk("corr_wr", {wr_q.size(), wr_q[0]}, {32'd1, 8'd2});
        chk("corr_data", mem[2], gold(2));
        chk("corr_cnt", {corr_cnt_o, uncorr_cnt_o}, {16'd1, 16'd0});
        chk("corr_lat", busy_cyc, 18);

        // Double error at 1, out-of-range location at 3.
        mem[1] = gold(1) ^ 31'h00000041;
        nerr_tab[1] = 2'd2;
        nerr_tab[3] = 2'd1; loc_tab[3] = 5'd31;
        start_pass(8'd0, 8'd3);
        wait_idle("unc_end");
        nerr_tab[3] = 2'd0;
        chk("unc_writes", wr_q.size(), 0);
        chk("unc_cnt", {corr_cnt_o, uncorr_cnt_o}, {16'd0, 16'd2});
        chk("unc_first", {first_bad_vld_o, first_bad_o}, {1'b1, 8'd1});

        // Wrapping pass.
        start_pass(8'hFE, 8'h01);
        wait_idle("wrap_end");
        chk("wrap_reads", {rd_q.size(), rd_q[0], rd_q[1], rd_q[2], rd_q[3]}, {32'd4, 32'hFEFF0001});
        chk("wrap_cnt", {corr_cnt_o, uncorr_cnt_o}, {16'd0, 16'd1});
        chk("wrap_done", done_cnt, 1);

        // Write-back stalled 10 cycles with stop asserted during the stall.
        mem[0] = gold(0) ^ 31'(1 << 3);
        nerr_tab[0] = 2'd1; loc_tab[0] = 5'd3;
        wr_stall = 10; stall_cyc = 0; stall_seen = 0; stable_ok = 1;
        start_pass(8'd0, 8'd3);
        for (int n = 0; n < 100 && !stall_seen; n++) @(negedge clk);
        chk("stall_seen", stall_seen, 1);
        stop_i = 1'b1;
        wait_idle("stall_end");
        stop_i = 1'b0;
        nerr_tab[0] = 2'd0;
        chk("stall_stable", stable_ok, 1);
        chk("stall_cyc", stall_cyc, 10);
        chk("stall_rw", {rd_q.size(), wr_q.size()}, {32'd1, 32'd1});
        chk("stall_data", mem[0], gold(0));
        chk("stall_done", {done_cnt, 16'(corr_cnt_o)}, {32'd1, 16'd1});

        // Start and stop in the same IDLE cycle: exactly one word is scrubbed.
        stop_i = 1'b1;
        start_pass(8'd5, 8'd9);
        wait_idle("ss_end");
        stop_i = 1'b0;
        chk("ss_reads", {rd_q.size(), rd_q[0]}, {32'd1, 8'd5});
        chk("ss_done", done_cnt, 1);

        // Reset while waiting for delayed read data at addr 2.
        rd_delay = 5; rd_delay_addr = 2;
        start_pass(8'd1, 8'd3);
        for (int n = 0; n < 100 && !(rd_q.size() == 2); n++) @(negedge clk);
        chk("pre_rst_uncorr", uncorr_cnt_o, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ctl", {busy_o, done_o, mem_req_o, mem_we_o}, 0);
        chk("mid_rst_cnt", {corr_cnt_o, uncorr_cnt_o, first_bad_vld_o}, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("late_rvalid", {busy_o, mem_req_o, dec_data_o}, 0);
        chk("late_reads", rd_q.size(), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
